chirp_sweep_gen: RTL and testbench
==================================

# chirp_sweep_gen

Upstream sequencer of the radar waveform chain: generates a stepped linear-FM frequency schedule (kHz codes) and drives the 10-bit `freq` input of the phase-increment stage, which in turn feeds the DDS. Runs a programmable burst of chirps (up, down or triangle), with a per-step dwell and an inter-chirp gap, started by a one-cycle strobe.

## Interface
- `FREQ_W`, 10: frequency code width, in kHz units; matches the phase-increment stage input.
- `CNT_W`, 16: width of the dwell and gap counters.
- `aclk`  in  1: single clock; all logic is on the rising edge.
- `aresetn`  in  1: reset; synchronous, active-low.
- `start`  in  1: one-cycle strobe; accepted only in IDLE.
- `abort`  in  1: returns to IDLE on the next edge, from any state.
- `mode`  in  2: 0 = up, 1 = down, 2 = triangle, 3 = up (reserved).
- `f_start`  in  FREQ_W: low sweep bound.
- `f_stop`  in  FREQ_W: high sweep bound.
- `f_step`  in  FREQ_W: step size.
- `dwell`  in  CNT_W: cycles per frequency step; 0 is treated as 1.
- `gap`  in  CNT_W: idle cycles between chirps; 0 means back-to-back.
- `n_chirps`  in  8: chirps per burst; 0 means continuous until `abort`.
- `freq`  out  FREQ_W: current frequency code (registered).
- `freq_valid`  out  1: high while `freq` is part of a chirp.
- `chirp_start`  out  1: one-cycle pulse on the first step of each chirp.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when the burst completes normally.

## Operation
- States: IDLE, RAMP_UP, RAMP_DN, GAP.
- All inputs other than `start` and `abort` are latched on an accepted `start`. Later input changes do not affect the running burst.
- `start` while busy is ignored.
- First step of a chirp:
  - up/triangle: `freq` = `f_start`, state RAMP_UP.
  - down: `freq` = `f_stop`, state RAMP_DN.
- Each step value is held for max(`dwell`, 1) cycles. Then the next step is computed.
- Up step: sum = `freq` + `f_step`, computed FREQ_W+1 bits wide. If sum ≥ `f_stop`, the next value is exactly `f_stop` (saturate, no wrap).
- The held `f_stop` step ends an up chirp. In triangle mode it switches to RAMP_DN instead.
- Down step: if `freq` − `f_step` ≤ `f_start` (borrow-safe compare), the next value is exactly `f_start`. The held `f_start` step ends the chirp.
- Triangle: the `f_stop` step is emitted once only (not repeated at the turn).
- Degenerate case: `f_step` = 0 or `f_start` ≥ `f_stop`. Each chirp is then a single step at `f_start` for one dwell, in all modes.
- End of chirp:
  - If more chirps remain (or continuous), go to GAP when `gap` > 0. Otherwise start the next chirp immediately.
  - If no chirps remain, pulse `done`, go to IDLE, drop `busy`.
- GAP lasts exactly `gap` cycles, with `freq_valid` = 0. Then a new chirp begins.
- Chirp counter: decrements at each chirp end; it is not decremented in continuous mode.
- `abort` has priority over `start` and over every transition:
  - next state IDLE, `freq_valid`/`busy` = 0, no `done`.
  - `freq` is held at its last value.
- Reset values: state IDLE; `freq` = 0, `freq_valid` = 0, `chirp_start` = 0, `busy` = 0, `done` = 0; counters 0.

## Timing
- `start` at edge k: `busy`, `freq_valid`, `chirp_start` and the first `freq` are valid after edge k+1.
- Step n+1 appears exactly max(`dwell`, 1) cycles after step n.
- Back-to-back chirps (`gap` = 0): the first step of chirp m+1 immediately follows the last dwell cycle of chirp m. `chirp_start` pulses on that cycle.
- `done` is asserted in the cycle after the final dwell cycle. `busy` is low in that same cycle, so a `start` is accepted there.
- Downstream phase-increment stage adds 2 cycles of `freq`→`phase_inc` latency. This block does not compensate for it.
- Reset asserted mid-burst: all outputs take their reset values on the next edge.

## Structure
- Package `chirp_pkg`:
  - state enum;
  - `mode` encodings (MODE_UP, MODE_DN, MODE_TRI);
  - FREQ_W / CNT_W defaults.
- Sub-module `dwell_timer`: loadable down-counter with a terminal-count pulse. It is reused for both the dwell and the gap.
- Top level: FSM, saturating step adder/subtractor, chirp counter, config latch.

## Test plan
- Up, `f_start`=100, `f_stop`=130, `f_step`=10, `dwell`=3, `n_chirps`=1, `gap`=0 -> `freq` 100, 110, 120, 130, each for 3 cycles; `done` 1 cycle after the last 130; `chirp_start` only at the first 100.
- Triangle, 100/125/10, `dwell`=1 -> sequence 100, 110, 120, 125, 115, 105, 100; a single 125 at the turn.
- `n_chirps`=3, `gap`=4, up, 0/20/10, `dwell`=2 -> three chirps of 0, 10, 20; exactly 4 cycles of `freq_valid`=0 between chirps; 3 `chirp_start` pulses; 1 `done`.
- Saturation: up, `f_start`=1000, `f_stop`=1023, `f_step`=50 -> 1000, 1023, with no wrap to a small value. Degenerate case: `f_step`=0 -> a single step at `f_start`.
- `n_chirps`=0 continuous, with `abort` in the 2nd chirp -> IDLE next cycle; `freq_valid` = `busy` = 0; no `done`. A `start` during the burst is ignored.
- `aresetn` low mid-ramp -> all outputs 0 on the next edge; a `start` after release runs a normal burst.

Source files
------------

// File: rtl/chirp_pkg.sv
// Shared types and constants for the chirp sweep generator.
package chirp_pkg;

    localparam int FREQ_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] MODE_UP  = 2'd0;
    localparam logic [1:0] MODE_DN  = 2'd1;
    localparam logic [1:0] MODE_TRI = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP_UP,
        S_RAMP_DN,
        S_GAP
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded interval.
module dwell_timer
    import chirp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Load a new interval, otherwise count down and park at zero.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign expire = (count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/chirp_sweep_gen.sv
// Stepped linear-FM frequency scheduler: bursts of up, down or triangle chirps
// with per-step dwell and an optional gap between chirps.
module chirp_sweep_gen
    import chirp_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [FREQ_W-1:0] f_start,
    input  logic [FREQ_W-1:0] f_stop,
    input  logic [FREQ_W-1:0] f_step,
    input  logic [CNT_W-1:0]  dwell,
    input  logic [CNT_W-1:0]  gap,
    input  logic [7:0]        n_chirps,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    output logic              chirp_start,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [FREQ_W-1:0] freq_nxt;
    logic              fv_nxt;
    logic              cs_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    logic [1:0]        cfg_mode;
    logic [FREQ_W-1:0] cfg_f_start;
    logic [FREQ_W-1:0] cfg_f_stop;
    logic [FREQ_W-1:0] cfg_f_step;
    logic [CNT_W-1:0]  cfg_dwell;
    logic [CNT_W-1:0]  cfg_gap;
    logic [7:0]        chirps_left;

    logic              cfg_load;
    logic              chirp_dec;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_expire;
    logic              end_chirp;
    logic              begin_chirp;

    logic              in_degen;
    logic              cfg_degen;
    logic              in_first_dn;
    logic              cfg_first_dn;
    logic [CNT_W-1:0]  in_dwell;

    // Saturating up step: the sum is one bit wider so it can never wrap.
    function automatic logic [FREQ_W-1:0] step_up(input logic [FREQ_W-1:0] f,
                                                  input logic [FREQ_W-1:0] step,
                                                  input logic [FREQ_W-1:0] hi);
        logic [FREQ_W:0] sum;
        sum = {1'b0, f} + {1'b0, step};
        if (sum >= {1'b0, hi}) return hi;
        return sum[FREQ_W-1:0];
    endfunction

    // Saturating down step: compare f against lo+step so no borrow can occur.
    function automatic logic [FREQ_W-1:0] step_dn(input logic [FREQ_W-1:0] f,
                                                  input logic [FREQ_W-1:0] step,
                                                  input logic [FREQ_W-1:0] lo);
        logic [FREQ_W:0] floor_sum;
        floor_sum = {1'b0, lo} + {1'b0, step};
        if ({1'b0, f} <= floor_sum) return lo;
        return f - step;
    endfunction

    assign in_degen     = (f_step == '0) || (f_start >= f_stop);
    assign cfg_degen    = (cfg_f_step == '0) || (cfg_f_start >= cfg_f_stop);
    assign in_first_dn  = (mode == MODE_DN) && !in_degen;
    assign cfg_first_dn = (cfg_mode == MODE_DN) && !cfg_degen;
    assign in_dwell     = (dwell == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : dwell;

    // Capture the burst configuration on an accepted start; count chirps down.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_mode    <= MODE_UP;
            cfg_f_start <= '0;
            cfg_f_stop  <= '0;
            cfg_f_step  <= '0;
            cfg_dwell   <= '0;
            cfg_gap     <= '0;
            chirps_left <= '0;
        end else if (cfg_load) begin
            cfg_mode    <= (mode == MODE_DN || mode == MODE_TRI) ? mode : MODE_UP;
            cfg_f_start <= f_start;
            cfg_f_stop  <= f_stop;
            cfg_f_step  <= f_step;
            cfg_dwell   <= in_dwell;
            cfg_gap     <= gap;
            chirps_left <= n_chirps;
        end else if (chirp_dec) begin
            chirps_left <= chirps_left - 8'd1;
        end
    end

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

    // Next-state and next-output logic; abort overrides every other transition.
    always_comb begin
        state_nxt   = state;
        freq_nxt    = freq;
        fv_nxt      = freq_valid;
        cs_nxt      = 1'b0;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = cfg_dwell;
        cfg_load    = 1'b0;
        chirp_dec   = 1'b0;
        end_chirp   = 1'b0;
        begin_chirp = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            fv_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    fv_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                    if (start) begin
                        cfg_load  = 1'b1;
                        state_nxt = in_first_dn ? S_RAMP_DN : S_RAMP_UP;
                        freq_nxt  = in_first_dn ? f_stop : f_start;
                        fv_nxt    = 1'b1;
                        cs_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = in_dwell;
                    end
                end
                S_RAMP_UP: begin
                    if (tmr_expire) begin
                        if (cfg_degen || (freq == cfg_f_stop && cfg_mode != MODE_TRI)) begin
                            end_chirp = 1'b1;
                        end else if (freq == cfg_f_stop) begin
                            state_nxt = S_RAMP_DN;
                            freq_nxt  = step_dn(freq, cfg_f_step, cfg_f_start);
                            tmr_load  = 1'b1;
                        end else begin
                            freq_nxt = step_up(freq, cfg_f_step, cfg_f_stop);
                            tmr_load = 1'b1;
                        end
                    end
                end
                S_RAMP_DN: begin
                    if (tmr_expire) begin
                        if (freq == cfg_f_start) begin
                            end_chirp = 1'b1;
                        end else begin
                            freq_nxt = step_dn(freq, cfg_f_step, cfg_f_start);
                            tmr_load = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (tmr_expire) begin
                        begin_chirp = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    fv_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase

            if (end_chirp) begin
                chirp_dec = (chirps_left != 8'd0);
                if (chirps_left == 8'd1) begin
                    state_nxt = S_IDLE;
                    fv_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else if (cfg_gap != '0) begin
                    state_nxt = S_GAP;
                    fv_nxt    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_val   = cfg_gap;
                end else begin
                    begin_chirp = 1'b1;
                end
            end

            if (begin_chirp) begin
                state_nxt = cfg_first_dn ? S_RAMP_DN : S_RAMP_UP;
                freq_nxt  = cfg_first_dn ? cfg_f_stop : cfg_f_start;
                fv_nxt    = 1'b1;
                cs_nxt    = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = cfg_dwell;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            freq        <= '0;
            freq_valid  <= 1'b0;
            chirp_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            freq        <= freq_nxt;
            freq_valid  <= fv_nxt;
            chirp_start <= cs_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Directed bench for chirp_sweep_gen with a per-cycle expected-output scoreboard.
module tb_chirp_sweep_gen;
    import chirp_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [9:0]  f_start;
    logic [9:0]  f_stop;
    logic [9:0]  f_step;
    logic [15:0] dwell;
    logic [15:0] gap;
    logic [7:0]  n_chirps;
    logic [9:0]  freq;
    logic        freq_valid;
    logic        chirp_start;
    logic        busy;
    logic        done;

    typedef struct {
        logic [9:0] f;
        bit         chk_f;
        bit         fv;
        bit         cs;
        bit         bsy;
        bit         dn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;

    chirp_sweep_gen #(
        .FREQ_W(10),
        .CNT_W (16)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .gap        (gap),
        .n_chirps   (n_chirps),
        .freq       (freq),
        .freq_valid (freq_valid),
        .chirp_start(chirp_start),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    task automatic push_entry(input logic [9:0] f, input bit chk_f, input bit fv,
                              input bit cs, input bit bsy, input bit dn);
        exp_t e;
        e.f = f; e.chk_f = chk_f; e.fv = fv; e.cs = cs; e.bsy = bsy; e.dn = dn;
        sb.push_back(e);
    endtask

    // Reference chirp: frequency list built with plain integer arithmetic.
    task automatic push_chirp(input logic [1:0] md, input int fs, input int fp,
                              input int st, input int dw);
        int vals[$];
        int v;
        int hold;
        hold = (dw == 0) ? 1 : dw;
        if (st == 0 || fs >= fp) begin
            vals.push_back(fs);
        end else begin
            if (md == 2'd1) begin
                v = fp;
                vals.push_back(v);
            end else begin
                v = fs;
                vals.push_back(v);
                while (v != fp) begin
                    v = (v + st >= fp) ? fp : v + st;
                    vals.push_back(v);
                end
            end
            if (md == 2'd1 || md == 2'd2) begin
                while (v != fs) begin
                    v = (v - st <= fs) ? fs : v - st;
                    vals.push_back(v);
                end
            end
        end
        for (int i = 0; i < vals.size(); i++)
            for (int d = 0; d < hold; d++)
                push_entry(10'(vals[i]), 1'b1, 1'b1, (i == 0 && d == 0), 1'b1, 1'b0);
    endtask

    task automatic push_burst(input logic [1:0] md, input int fs, input int fp, input int st,
                              input int dw, input int g, input int n, input bit tail_idle);
        int chirps;
        chirps = (n == 0) ? 2 : n;
        for (int c = 0; c < chirps; c++) begin
            push_chirp(md, fs, fp, st, dw);
            if (c < chirps - 1)
                for (int k = 0; k < g; k++) push_entry(10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        if (n != 0) push_entry(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (tail_idle) push_entry(10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive a burst configuration, record its expected trace, pulse start.
    task automatic applyStimulus(input logic [1:0] md, input int fs, input int fp, input int st,
                                 input int dw, input int g, input int n, input bit tail_idle);
        mode     = md;
        f_start  = fs[9:0];
        f_stop   = fp[9:0];
        f_step   = st[9:0];
        dwell    = dw[15:0];
        gap      = g[15:0];
        n_chirps = n[7:0];
        push_burst(md, fs, fp, st, dw, g, n, tail_idle);
        start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
    endtask

    // Pop n expected entries, one per cycle, and compare at the falling edge.
    task automatic checkOutput(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            e = sb.pop_front();
            step_no++;
            total++;
            assert (freq_valid === e.fv) else begin
                bad++;
                $error("FAIL freq_valid step=%0d got=%b exp=%b", step_no, freq_valid, e.fv);
            end
            total++;
            assert (chirp_start === e.cs) else begin
                bad++;
                $error("FAIL chirp_start step=%0d got=%b exp=%b", step_no, chirp_start, e.cs);
            end
            total++;
            assert (busy === e.bsy) else begin
                bad++;
                $error("FAIL busy step=%0d got=%b exp=%b", step_no, busy, e.bsy);
            end
            total++;
            assert (done === e.dn) else begin
                bad++;
                $error("FAIL done step=%0d got=%b exp=%b", step_no, done, e.dn);
            end
            if (e.chk_f) begin
                total++;
                assert (freq === e.f) else begin
                    bad++;
                    $error("FAIL freq step=%0d got=%0d exp=%0d", step_no, freq, e.f);
                end
            end
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0; gap = '0; n_chirps = '0;

        $display("[TB] reset values");
        push_entry(10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput(1);
        aresetn = 1'b1;

        $display("[TB] up ramp 100..130 step 10 dwell 3");
        applyStimulus(MODE_UP, 100, 130, 10, 3, 0, 1, 1'b1);
        checkOutput(sb.size());

        $display("[TB] triangle 100..125 step 10 dwell 1");
        applyStimulus(MODE_TRI, 100, 125, 10, 1, 0, 1, 1'b1);
        checkOutput(sb.size());

        $display("[TB] three chirps with gap 4");
        applyStimulus(MODE_UP, 0, 20, 10, 2, 4, 3, 1'b1);
        checkOutput(sb.size());

        $display("[TB] down, dwell 0, back-to-back pair");
        applyStimulus(MODE_DN, 100, 130, 10, 0, 0, 2, 1'b1);
        checkOutput(sb.size());

        $display("[TB] saturation near full scale");
        applyStimulus(MODE_UP, 1000, 1023, 50, 1, 0, 1, 1'b0);
        checkOutput(sb.size());

        $display("[TB] degenerate step 0, started in the done cycle");
        applyStimulus(MODE_DN, 200, 300, 0, 2, 0, 1, 1'b1);
        checkOutput(sb.size());

        $display("[TB] degenerate start above stop, triangle");
        applyStimulus(MODE_TRI, 300, 200, 10, 1, 1, 2, 1'b1);
        checkOutput(sb.size());

        $display("[TB] continuous burst, ignored start, abort in second chirp");
        applyStimulus(MODE_UP, 0, 30, 10, 2, 2, 0, 1'b0);
        repeat (5) void'(sb.pop_back());
        checkOutput(3);
        start = 1'b1; mode = MODE_DN; f_start = 10'd500; dwell = 16'd9;
        checkOutput(1);
        start = 1'b0;
        checkOutput(9);
        abort = 1'b1;
        push_entry(10'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_entry(10'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput(1);
        abort = 1'b0;
        checkOutput(1);

        $display("[TB] reset mid-ramp, then a fresh burst");
        applyStimulus(MODE_UP, 100, 130, 10, 3, 0, 1, 1'b1);
        repeat (10) void'(sb.pop_back());
        checkOutput(4);
        aresetn = 1'b0;
        push_entry(10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput(1);
        aresetn = 1'b1;
        applyStimulus(2'd3, 100, 130, 10, 3, 0, 1, 1'b1);
        checkOutput(sb.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
